// File: rtl/edge_window_buffer.sv
// Streaming 4-neighbour window former: two rotating line buffers plus tap registers
// turn a raster pixel stream into {up, right, down, left} blocks for interior pixels.
module edge_window_buffer #(
    parameter int LINE_WIDTH  = 640,
    parameter int FRAME_LINES = 480
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        frame_start,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic [31:0] block_out,
    output logic        block_valid,
    input  logic        block_ready,
    output logic [9:0]  block_x,
    output logic [8:0]  block_y,
    output logic        block_last,
    output logic        frame_overrun
);

    localparam int         AW       = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [9:0] COL_LAST = 10'(LINE_WIDTH - 1);
    localparam logic [8:0] ROW_LAST = 9'(FRAME_LINES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  col_q, col_d;
    logic [8:0]  row_q, row_d;
    logic        sel_q, sel_d;
    logic        overrun_q, overrun_d;

    // sel_q = 1: lb1 holds row r-1 and lb0 holds row r-2; swapped on every row advance.
    logic [7:0]  lb0_q [LINE_WIDTH];
    logic [7:0]  lb1_q [LINE_WIDTH];

    logic [7:0]  cur_prev_q;
    logic [7:0]  rm1_d1_q;
    logic [7:0]  rm1_d2_q;
    logic [7:0]  rm2_d1_q;

    logic        blk_valid_q, blk_valid_d;
    logic [31:0] blk_data_q, blk_data_d;
    logic [9:0]  blk_x_q, blk_x_d;
    logic [8:0]  blk_y_q, blk_y_d;
    logic        blk_last_q, blk_last_d;

    logic          accept_s;
    logic          adv_s;
    logic          gen_s;
    logic          last_pix_s;
    logic [9:0]    col_eff_s;
    logic [8:0]    row_eff_s;
    logic [AW-1:0] addr_s;
    logic [7:0]    rm1_rd_s;
    logic [7:0]    rm2_rd_s;

    // Handshake, effective pixel position and line-buffer read taps.
    always_comb begin
        case (state_q)
            ST_RUN:  pixel_ready = !blk_valid_q || block_ready;
            ST_DONE: pixel_ready = 1'b1;
            default: pixel_ready = 1'b0;
        endcase
        accept_s   = pixel_valid && pixel_ready;
        col_eff_s  = frame_start ? 10'd0 : col_q;
        row_eff_s  = frame_start ? 9'd0  : row_q;
        addr_s     = col_eff_s[AW-1:0];
        // A pixel accepted in DONE belongs to a frame only if frame_start opens it.
        adv_s      = accept_s && ((state_q == ST_RUN) || frame_start);
        last_pix_s = (row_eff_s == ROW_LAST) && (col_eff_s == COL_LAST);
        gen_s      = adv_s && (row_eff_s >= 9'd2) && (col_eff_s >= 10'd2);
        rm1_rd_s   = sel_q ? lb1_q[addr_s] : lb0_q[addr_s];
        rm2_rd_s   = sel_q ? lb0_q[addr_s] : lb1_q[addr_s];
    end

    // Next-state: frame FSM, raster counters, overrun flag and output register.
    always_comb begin
        if (adv_s) begin
            if (col_eff_s == COL_LAST) begin
                col_d = 10'd0;
                sel_d = ~sel_q;
                if (row_eff_s == ROW_LAST) begin
                    row_d = 9'd0;
                end else begin
                    row_d = row_eff_s + 9'd1;
                end
            end else begin
                col_d = col_eff_s + 10'd1;
                row_d = row_eff_s;
                sel_d = sel_q;
            end
        end else begin
            col_d = col_eff_s;
            row_d = row_eff_s;
            sel_d = sel_q;
        end

        if (adv_s && last_pix_s) begin
            state_d = ST_DONE;
        end else if (frame_start) begin
            state_d = ST_RUN;
        end else begin
            state_d = state_q;
        end

        if (accept_s && (state_q == ST_DONE) && !frame_start) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        if (gen_s) begin
            blk_valid_d = 1'b1;
            blk_data_d  = {rm2_d1_q, rm1_rd_s, cur_prev_q, rm1_d2_q};
            blk_x_d     = col_eff_s - 10'd1;
            blk_y_d     = row_eff_s - 9'd1;
            blk_last_d  = last_pix_s;
        end else begin
            blk_valid_d = blk_valid_q && !block_ready;
            blk_data_d  = blk_data_q;
            blk_x_d     = blk_x_q;
            blk_y_d     = blk_y_q;
            blk_last_d  = blk_last_q;
        end
    end

    // Control, tap and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            col_q       <= 10'd0;
            row_q       <= 9'd0;
            sel_q       <= 1'b0;
            overrun_q   <= 1'b0;
            cur_prev_q  <= 8'd0;
            rm1_d1_q    <= 8'd0;
            rm1_d2_q    <= 8'd0;
            rm2_d1_q    <= 8'd0;
            blk_valid_q <= 1'b0;
            blk_data_q  <= 32'd0;
            blk_x_q     <= 10'd0;
            blk_y_q     <= 9'd0;
            blk_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            sel_q       <= sel_d;
            overrun_q   <= overrun_d;
            blk_valid_q <= blk_valid_d;
            blk_data_q  <= blk_data_d;
            blk_x_q     <= blk_x_d;
            blk_y_q     <= blk_y_d;
            blk_last_q  <= blk_last_d;
            if (adv_s) begin
                cur_prev_q <= pixel_in;
                rm1_d2_q   <= rm1_d1_q;
                rm1_d1_q   <= rm1_rd_s;
                rm2_d1_q   <= rm2_rd_s;
            end
        end
    end

    // The incoming pixel overwrites the row r-2 slot that was just read into the up tap.
    always_ff @(posedge clock) begin
        if (adv_s) begin
            if (sel_q) begin
                lb0_q[addr_s] <= pixel_in;
            end else begin
                lb1_q[addr_s] <= pixel_in;
            end
        end
    end

    assign block_valid   = blk_valid_q;
    assign block_out     = blk_data_q;
    assign block_x       = blk_x_q;
    assign block_y       = blk_y_q;
    assign block_last    = blk_last_q;
    assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_edge_window_buffer.sv
// Self-checking bench for edge_window_buffer on a 6x5 frame: an image-level reference
// model predicts every block; a monitor checks transfers, stalls and backpressure.
module tb_edge_window_buffer;

    localparam int LW   = 6;
    localparam int FL   = 5;
    localparam int NPIX = LW * FL;
    localparam int NBLK = (LW - 2) * (FL - 2);

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_start = 1'b0;
    logic [7:0]  pixel_in = 8'd0;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic [31:0] block_out;
    logic        block_valid;
    logic        block_ready = 1'b1;
    logic [9:0]  block_x;
    logic [8:0]  block_y;
    logic        block_last;
    logic        frame_overrun;

    typedef struct packed {
        logic [31:0] d;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        l;
    } blk_t;

    blk_t       exp_q[$];
    blk_t       obs_q[$];
    logic [7:0] img [FL][LW];
    int         n_checks = 0;
    int         n_fail = 0;
    int         blk_count = 0;
    int         last_count = 0;
    int         ready_mode = 1;

    edge_window_buffer #(.LINE_WIDTH(LW), .FRAME_LINES(FL)) dut (
        .clock(clock), .resetn(resetn), .frame_start(frame_start),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .block_out(block_out), .block_valid(block_valid), .block_ready(block_ready),
        .block_x(block_x), .block_y(block_y), .block_last(block_last),
        .frame_overrun(frame_overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every interior centre whose generating pixel (cy+1, cx+1) lies among the first n pixels.
    task automatic build_expected(input int n);
        blk_t b;
        for (int cy = 1; cy <= FL - 2; cy++) begin
            for (int cx = 1; cx <= LW - 2; cx++) begin
                if ((cy + 1) * LW + (cx + 1) < n) begin
                    b.d = {img[cy-1][cx], img[cy][cx+1], img[cy+1][cx], img[cy][cx-1]};
                    b.x = 10'(cx);
                    b.y = 9'(cy);
                    b.l = (cy == FL - 2) && (cx == LW - 2);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < FL; r++)
            for (int c = 0; c < LW; c++)
                img[r][c] = 8'(16 * r + c);
    endtask

    task automatic fill_random();
        for (int r = 0; r < FL; r++)
            for (int c = 0; c < LW; c++)
                img[r][c] = 8'($urandom_range(0, 255));
    endtask

    task automatic send_pixel(input logic [7:0] p, input logic fs);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        @(negedge clock);
        pixel_in    = p;
        pixel_valid = 1'b1;
        frame_start = fs;
        while (!acc && n < 64) begin
            #4;
            acc = pixel_ready;
            @(posedge clock);
            n++;
            if (!acc) begin
                @(negedge clock);
                frame_start = 1'b0;
            end
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL pixel_accept_timeout: got no pixel_ready in %0d cycles, expected acceptance", n);
        end
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) send_pixel(img[i / LW][i % LW], i == 0);
    endtask

    task automatic idle_inputs();
        @(negedge clock);
        pixel_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic clear_counts();
        blk_count  = 0;
        last_count = 0;
        obs_q.delete();
    endtask

    // Drives block_ready according to the selected pattern.
    initial begin
        forever begin
            @(negedge clock);
            case (ready_mode)
                0:       block_ready = 1'b0;
                2:       block_ready = ~block_ready;
                default: block_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares each output transfer with the model and checks stall behaviour.
    initial begin
        blk_t cur;
        blk_t prev;
        blk_t e;
        logic prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clock);
            #4;
            cur = {block_out, block_x, block_y, block_last};
            if (!resetn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(block_valid), 64'd1);
                    chk("stall_hold", 64'(cur), 64'(prev));
                end
                if (block_valid && !block_ready && !block_last)
                    chk("pixel_ready_backpressure", 64'(pixel_ready), 64'd0);
                if (block_valid && block_ready) begin
                    blk_count++;
                    if (block_last) last_count++;
                    obs_q.push_back(cur);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_block: got %h x=%0d y=%0d, expected no block", block_out, block_x, block_y);
                    end else begin
                        e = exp_q.pop_front();
                        chk("block_out", 64'(cur.d), 64'(e.d));
                        chk("block_x", 64'(cur.x), 64'(e.x));
                        chk("block_y", 64'(cur.y), 64'(e.y));
                        chk("block_last", 64'(cur.l), 64'(e.l));
                    end
                end
                prev_stall = block_valid && !block_ready;
                prev = cur;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t pin_first;
        blk_t pin_last;
        pin_first = {32'h01122110, 10'd1, 9'd1, 1'b0};
        pin_last  = {32'h24354433, 10'd4, 9'd3, 1'b1};

        repeat (2) @(negedge clock);
        #1;
        chk("rst_block_valid", 64'(block_valid), 64'd0);
        chk("rst_pixel_ready", 64'(pixel_ready), 64'd0);
        chk("rst_block_out", 64'(block_out), 64'd0);
        chk("rst_xy_last", 64'({block_x, block_y, block_last}), 64'd0);
        chk("rst_overrun", 64'(frame_overrun), 64'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Frame A: ramp pattern, downstream always ready.
        clear_counts();
        fill_pattern();
        build_expected(NPIX);
        chk("model_first", 64'(exp_q[0]), 64'(pin_first));
        chk("model_last", 64'(exp_q[exp_q.size() - 1]), 64'(pin_last));
        feed(NPIX);
        idle_inputs();
        wait_drain("A");
        chk("A_count", 64'(blk_count), 64'(NBLK));
        chk("A_last_count", 64'(last_count), 64'd1);
        chk("A_first", 64'(obs_q[0]), 64'(pin_first));
        chk("A_final", 64'(obs_q[obs_q.size() - 1]), 64'(pin_last));
        chk("A_overrun", 64'(frame_overrun), 64'd0);

        // Extra pixels after the frame end: discarded, overrun latches.
        clear_counts();
        for (int i = 0; i < 3; i++) send_pixel(8'(8'hE0 + i), 1'b0);
        idle_inputs();
        repeat (4) @(negedge clock);
        chk("overrun_set", 64'(frame_overrun), 64'd1);
        chk("overrun_no_blocks", 64'(blk_count), 64'd0);

        // Frame B: same ramp with block_ready toggling every cycle.
        clear_counts();
        ready_mode = 2;
        fill_pattern();
        build_expected(NPIX);
        feed(NPIX);
        idle_inputs();
        wait_drain("B");
        ready_mode = 1;
        chk("B_count", 64'(blk_count), 64'(NBLK));
        chk("B_last_count", 64'(last_count), 64'd1);
        chk("B_first", 64'(obs_q[0]), 64'(pin_first));
        chk("B_final", 64'(obs_q[obs_q.size() - 1]), 64'(pin_last));
        chk("B_overrun_sticky", 64'(frame_overrun), 64'd1);

        // Frame C: random data aborted after one block, restarted with a pixel in the frame_start cycle.
        clear_counts();
        repeat (2) @(negedge clock);
        fill_random();
        build_expected(2 * LW + 3);
        feed(2 * LW + 3);
        fill_random();
        build_expected(NPIX);
        feed(NPIX);
        idle_inputs();
        wait_drain("C");
        chk("C_count", 64'(blk_count), 64'(NBLK + 1));
        chk("C_last_count", 64'(last_count), 64'd1);

        // Frame D: restart mid-row 2 while an output block is stalled.
        clear_counts();
        repeat (2) @(negedge clock);
        fill_random();
        build_expected(2 * LW + 4);
        feed(2 * LW + 4);
        ready_mode = 0;
        fill_random();
        build_expected(NPIX);
        fork
            feed(NPIX);
            begin
                repeat (3) @(negedge clock);
                ready_mode = 1;
            end
        join
        idle_inputs();
        wait_drain("D");
        chk("D_count", 64'(blk_count), 64'(NBLK + 2));
        chk("D_last_count", 64'(last_count), 64'd1);

        // Frame E: asynchronous reset while a block is pending.
        clear_counts();
        repeat (2) @(negedge clock);
        fill_random();
        feed(2 * LW + 3);
        ready_mode = 0;
        @(negedge clock);
        #1;
        chk("E_pending_before_reset", 64'(block_valid), 64'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("E_async_valid", 64'(block_valid), 64'd0);
        chk("E_async_out", 64'({block_out, block_x, block_y, block_last}), 64'd0);
        chk("E_async_overrun", 64'(frame_overrun), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        ready_mode = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            pixel_in    = 8'hAA;
            pixel_valid = 1'b1;
            #4;
            chk("E_idle_not_ready", 64'(pixel_ready), 64'd0);
        end
        chk("E_idle_no_blocks", 64'(blk_count), 64'd0);

        // Frame F: clean random frame after reset.
        clear_counts();
        fill_random();
        build_expected(NPIX);
        feed(NPIX);
        idle_inputs();
        wait_drain("F");
        chk("F_count", 64'(blk_count), 64'(NBLK));
        chk("F_last_count", 64'(last_count), 64'd1);
        chk("F_overrun", 64'(frame_overrun), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
